// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 8:1 mux tree.
// Fair rotating priority, bounded hold under contention, back-to-back handover.
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       busy
);

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_reg, state_next;
  logic [2:0] ptr_reg, ptr_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [7:0] grant_reg, grant_next;
  logic [2:0] sel_reg, sel_next;

  logic [7:0] pick_mask;
  logic [2:0] pick_start;
  logic [2:0] win_idx;
  logic [7:0] win_onehot;
  logic [7:0] holder_onehot;
  logic       others_pending;

  // First set bit of mask, scanning start, start+1, ... with wrap at 8.
  function automatic logic [2:0] rr_pick(input logic [7:0] mask, input logic [2:0] start);
    logic [2:0] idx;
    logic       found;
    rr_pick = start;
    found   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = start + 3'(k);
      if (!found && mask[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_decode
      assign win_onehot[gi]    = (win_idx == 3'(gi));
      assign holder_onehot[gi] = (sel_reg == 3'(gi));
    end
  endgenerate

  // Search window: idle searches all requests from ptr; a holder searches
  // the others starting just after itself.
  always_comb begin
    pick_mask  = req;
    pick_start = ptr_reg;
    if (state_reg == GRANT) begin
      pick_mask  = req & ~holder_onehot;
      pick_start = sel_reg + 3'd1;
    end
  end

  assign win_idx        = rr_pick(pick_mask, pick_start);
  assign others_pending = |pick_mask;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    grant_next = grant_reg;
    sel_next   = sel_reg;
    case (state_reg)
      IDLE: begin
        grant_next = '0;
        if (others_pending) begin
          grant_next = win_onehot;
          sel_next   = win_idx;
          cnt_next   = 8'd1;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (!req[sel_reg]) begin
          ptr_next = sel_reg + 3'd1;
          if (others_pending) begin
            grant_next = win_onehot;
            sel_next   = win_idx;
            cnt_next   = 8'd1;
          end else begin
            grant_next = '0;
            cnt_next   = '0;
            state_next = IDLE;
          end
        end else if ((cnt_reg >= HOLD_MAX) && others_pending) begin
          ptr_next   = sel_reg + 3'd1;
          grant_next = win_onehot;
          sel_next   = win_idx;
          cnt_next   = 8'd1;
        end else if (cnt_reg < HOLD_MAX) begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      grant_reg <= '0;
      sel_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      grant_reg <= grant_next;
      sel_reg   <= sel_next;
    end
  end

  assign grant = grant_reg;
  assign sel   = sel_reg;
  assign busy  = |grant_reg;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with MAX_HOLD=4 and hand-computed grants.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       busy;

  int n_checks = 0;
  int n_fails  = 0;

  mux_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .grant (grant),
    .sel   (sel),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] g, input logic [2:0] s, input logic b);
    chk({tag, "_grant"}, grant, g);
    chk({tag, "_sel"}, {5'd0, sel}, {5'd0, s});
    chk({tag, "_busy"}, {7'd0, busy}, {7'd0, b});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_g;
    reset = 1'b1;
    req   = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_out("reset_state", 8'h00, 3'd0, 1'b0);

    // Full contention: 4 cycles each, rotating from requester 0.
    tick();
    req = 8'hFF;
    for (int c = 0; c < 36; c++) begin
      tick();
      exp_g = 8'h01 << ((c / 4) % 8);
      chk($sformatf("contend_%0d", c), grant, exp_g);
      chk($sformatf("contend_busy_%0d", c), {7'd0, busy}, 8'h01);
    end
    req = 8'h00;
    tick();
    chk_out("contend_release", 8'h00, 3'd0, 1'b0);

    // Single request and release; sel retained in idle.
    req = 8'h08;
    tick();
    chk_out("single_grant", 8'h08, 3'd3, 1'b1);
    req = 8'h00;
    tick();
    chk_out("single_release", 8'h00, 3'd3, 1'b0);

    // Early release by requester 0 after two granted cycles.
    req = 8'h01;
    tick();
    chk_out("early_c1", 8'h01, 3'd0, 1'b1);
    req = 8'h21;
    tick();
    chk_out("early_c2", 8'h01, 3'd0, 1'b1);
    req = 8'h20;
    tick();
    chk_out("early_handover", 8'h20, 3'd5, 1'b1);

    // Uncontended saturated hold by requester 7, then wrap to requester 0.
    req = 8'h80;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk($sformatf("hold7_%0d", c), grant, 8'h80);
    end
    req = 8'h81;
    tick();
    chk_out("wrap_preempt", 8'h01, 3'd0, 1'b1);

    // Holder 2 with its own bit only must not preempt itself.
    req = 8'h04;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("hold2_%0d", c), grant, 8'h04);
    end
    chk({5'd0, sel}, {5'd0, sel}, 8'h02) ;
    req = 8'h44;
    tick();
    chk_out("masked_preempt", 8'h40, 3'd6, 1'b1);

    // Asynchronous reset between edges during an active grant.
    #3;
    reset = 1'b1;
    #1;
    chk_out("async_reset", 8'h00, 3'd0, 1'b0);
    req = 8'hFF;
    @(negedge clk);
    chk_out("reset_held", 8'h00, 3'd0, 1'b0);
    reset = 1'b0;
    #1;
    chk_out("reset_released", 8'h00, 3'd0, 1'b0);
    tick();
    chk_out("first_after_reset", 8'h01, 3'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
